trace_capture: RTL and testbench

- Receiving end of the per-cycle 8-bit reduced leakage stream (byte-parity vector) produced by the modular-exponentiation block.
- Arms, waits for a round-start trigger, and captures a fixed-length window of samples into an internal buffer.
- Drains the buffer to a host or UART-side reader over a valid/ready handshake.
- Shares the exponentiator's divided clock so that one sample is taken per exponent-bit step.

---
 rtl/trace_capture.sv | 135 +++++++++++++
 tb/tb_trace_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// Trace capture buffer: arms on request, starts a fixed-length window on the
// round-start trigger, captures valid leakage bytes, then drains them over valid/ready.
module trace_capture #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       trig,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       busy,
  output logic [7:0] sig
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      sig_q, sig_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic            busy_q, busy_d;
  logic            wr_en;
  logic [AW-1:0]   rd_ptr_inc;
  logic [7:0]      mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sig_d      = sig_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    wr_en      = 1'b0;
    rd_ptr_inc = rd_ptr_q + AW'(1);

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          sig_d   = 8'h00;
        end
      end
      ARMED: begin
        if (trig) begin
          state_d = CAPTURE;
          if (sample_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            sig_d    = sample_in;
          end
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          sig_d    = sig_q ^ sample_in;
          // Final write lands in the top entry, so buf[0] is already stable to preload.
          if (wr_ptr_q == LAST_IDX) begin
            state_d    = DRAIN;
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_ptr_q];
            rd_last_d  = (rd_ptr_q == LAST_IDX);
          end
        end
      end
      DRAIN: begin
        if (rd_valid_q && rd_ready) begin
          if (rd_last_q) begin
            state_d    = IDLE;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_data_d  = 8'h00;
          end else begin
            rd_ptr_d  = rd_ptr_inc;
            rd_data_d = mem[rd_ptr_inc];
            rd_last_d = (rd_ptr_inc == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sig_q      <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sig_q      <= sig_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
    end
  end

  // Sample storage has no reset; contents are only meaningful inside a window.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= sample_in;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign sig      = sig_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed-plus-random bench for trace_capture; the expected window is a queue of
// the bytes offered on valid cycles, and the expected signature is their XOR.
module tb_trace_capture;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       trig;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_last;
  logic       busy;
  logic [7:0] sig;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  trace_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .trig         (trig),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .busy         (busy),
    .sig          (sig)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] window_xor();
    logic [7:0] acc = 8'h00;
    foreach (exp_q[i]) acc ^= exp_q[i];
    return acc;
  endfunction

  // mode 0: index, 1: 0xA5, 2: 0xFF, 3: random, 4: 0x3C first then random
  function automatic logic [7:0] sample_value(input int mode, input int n);
    case (mode)
      0:       return 8'(n);
      1:       return 8'hA5;
      2:       return 8'hFF;
      4:       return (n == 0) ? 8'h3C : 8'($urandom);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_output({tag, ".rd_valid"}, {7'd0, rd_valid}, 8'h00);
    check_output({tag, ".rd_last"},  {7'd0, rd_last},  8'h00);
    check_output({tag, ".rd_data"},  rd_data,          8'h00);
    check_output({tag, ".busy"},     {7'd0, busy},     8'h00);
  endtask

  task automatic apply_stimulus_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_output("arm.busy", {7'd0, busy}, 8'h01);
    check_output("arm.sig",  sig,          8'h00);
    check_output("arm.rd_valid", {7'd0, rd_valid}, 8'h00);
  endtask

  // Starts in ARMED; the trigger cycle is the first cycle of this task.
  task automatic apply_stimulus_capture(input int mode, input bit trig_valid,
                                        input bit gaps, input bit noise);
    int  n = 0;
    int  cyc = 0;
    bit  first = 1'b1;
    bit  v;
    exp_q.delete();
    while (n < DEPTH && cyc < 2000) begin
      trig = first;
      arm  = 1'b0;
      if (first)     v = trig_valid;
      else if (gaps) v = ($urandom_range(0, 2) != 0);
      else           v = 1'b1;
      if (!first && noise) begin
        trig = 1'($urandom_range(0, 1));
        arm  = 1'($urandom_range(0, 1));
      end
      sample_valid = v;
      sample_in    = v ? sample_value(mode, n) : 8'($urandom);
      if (v) begin
        exp_q.push_back(sample_in);
        n++;
      end
      first = 1'b0;
      tick();
      cyc++;
      if (n < DEPTH) begin
        check_output("cap.busy",     {7'd0, busy},     8'h01);
        check_output("cap.rd_valid", {7'd0, rd_valid}, 8'h00);
      end
    end
    trig = 1'b0;
    arm = 1'b0;
    sample_valid = 1'b0;
    check_output("cap.done", (n == DEPTH) ? 8'h01 : 8'h00, 8'h01);
    check_output("cap.first_read_latency", {7'd0, rd_valid}, 8'h01);
  endtask

  // ready_mode 0: always, 1: 1,0,0 repeating, 2: random. Stops early at stop_after.
  task automatic apply_stimulus_drain(input int ready_mode, input bit noise, input int stop_after);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < stop_after && cyc < 2000) begin
      check_output("drn.rd_valid", {7'd0, rd_valid}, 8'h01);
      check_output($sformatf("drn.rd_data[%0d]", idx), rd_data, exp_q[idx]);
      check_output($sformatf("drn.rd_last[%0d]", idx), {7'd0, rd_last},
                   (idx == DEPTH - 1) ? 8'h01 : 8'h00);
      check_output("drn.busy", {7'd0, busy}, 8'h01);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        trig         = 1'($urandom_range(0, 1));
        arm          = 1'($urandom_range(0, 1));
        sample_valid = 1'b1;
        sample_in    = 8'($urandom);
      end
      rd_ready = rdy;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    rd_ready = 1'b0;
    trig = 1'b0;
    arm = 1'b0;
    sample_valid = 1'b0;
    check_output("drn.count", (idx == stop_after) ? 8'h01 : 8'h00, 8'h01);
    if (stop_after == DEPTH) begin
      check_idle_outputs("drn.end");
      check_output("drn.sig", sig, window_xor());
      tick();
      check_idle_outputs("drn.after");
    end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    trig = 1'b0;
    sample_in = 8'h00;
    sample_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check_output("reset.sig", sig, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] idle ignores trig");
    trig = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'h77;
    tick();
    trig = 1'b0;
    sample_valid = 1'b0;
    check_idle_outputs("idle_trig");

    $display("[TB] index window, reader always ready");
    apply_stimulus_arm();
    apply_stimulus_capture(0, 1'b1, 1'b0, 1'b0);
    apply_stimulus_drain(0, 1'b0, DEPTH);
    check_output("t1.sig_zero", sig, 8'h00);

    $display("[TB] index window, stalling reader");
    apply_stimulus_arm();
    apply_stimulus_capture(0, 1'b1, 1'b0, 1'b0);
    apply_stimulus_drain(1, 1'b0, DEPTH);

    $display("[TB] invalid trigger sample, 0xA5 with gaps");
    apply_stimulus_arm();
    apply_stimulus_capture(1, 1'b0, 1'b1, 1'b0);
    apply_stimulus_drain(2, 1'b0, DEPTH);
    check_output("t3.sig_zero", sig, 8'h00);

    $display("[TB] random window with trig/arm/sample noise");
    apply_stimulus_arm();
    apply_stimulus_capture(3, 1'b1, 1'b1, 1'b1);
    apply_stimulus_drain(2, 1'b1, DEPTH);

    $display("[TB] async reset during drain");
    apply_stimulus_arm();
    apply_stimulus_capture(3, 1'b1, 1'b0, 1'b0);
    apply_stimulus_drain(0, 1'b0, 10);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check_output("async_rst.sig", sig, 8'h00);
    #2;
    rst = 1'b0;
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    check_idle_outputs("post_rst");
    apply_stimulus_arm();
    apply_stimulus_capture(2, 1'b1, 1'b0, 1'b0);
    apply_stimulus_drain(0, 1'b0, DEPTH);

    $display("[TB] arm and trig together in idle");
    arm = 1'b1;
    trig = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'h99;
    tick();
    arm = 1'b0;
    check_output("armtrig.busy", {7'd0, busy}, 8'h01);
    check_output("armtrig.sig", sig, 8'h00);
    apply_stimulus_capture(4, 1'b1, 1'b0, 1'b0);
    check_output("armtrig.first_read", rd_data, 8'h3C);
    apply_stimulus_drain(2, 1'b0, DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
